// File: rtl/sha256_host_driver.sv
// sha256_host_driver
//   Host-side initiator for an 8-bit SHA-256 core. Accepts a 1..55 byte
//   message on a valid/ready stream, pads it to a single 64-byte block,
//   loads the block into the core byte by byte, starts the compression,
//   waits for the digest and streams the 32 digest bytes back out.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   msg_*             message byte stream in (data/valid/last/ready)
//   dig_*             digest byte stream out, H0 MSB first, last on byte 31
//   core_input_bus    byte presented to the core with core_load
//   core_load         one-cycle load strobe
//   core_start        one-cycle compression start strobe
//   core_read         one-cycle strobe advancing core_output_data
//   core_hash_ready   core digest available
//   core_output_data  current digest byte from the core
//   busy              high in every state except IDLE
//   err_overflow      sticky: message longer than MAX_MSG_BYTES
//   err_timeout       sticky: core never raised hash_ready
module sha256_host_driver #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_MSG_BYTES  = 55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic [7:0] dig_data,
  output logic       dig_valid,
  output logic       dig_last,
  input  logic       dig_ready,
  output logic [7:0] core_input_bus,
  output logic       core_load,
  output logic       core_start,
  output logic       core_read,
  input  logic       core_hash_ready,
  input  logic [7:0] core_output_data,
  output logic       busy,
  output logic       err_overflow,
  output logic       err_timeout
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [5:0] MSG_MAX   = 6'(MAX_MSG_BYTES);
  localparam logic [5:0] LAST_LOAD = 6'd63;
  localparam logic [4:0] LAST_DIG  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_MSG, S_PAD, S_START, S_WAIT_HASH, S_RD_CAP, S_RD_OUT, S_RD_GAP
  } state_t;

  state_t state, state_nxt;

  logic [5:0]       count, count_nxt;        // message bytes loaded
  logic [5:0]       load_cnt, load_cnt_nxt;  // total bytes loaded into the block
  logic [4:0]       rd_idx, rd_idx_nxt;      // digest byte index
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;

  logic       load_nxt, start_nxt, read_nxt;
  logic [7:0] bus_nxt, dig_data_nxt;
  logic       dig_valid_nxt, dig_last_nxt;
  logic       err_ovf_nxt, err_tmo_nxt;

  logic msg_fire;
  logic tmo_hit;

  // Padding byte for block position idx of a msg_len-byte message:
  // 0x80 terminator, zero fill, then the 64-bit big-endian bit length
  // (only the low 9 bits can be non-zero for a single-block message).
  function automatic logic [7:0] pad_byte(input logic [5:0] idx,
                                          input logic [5:0] msg_len);
    logic [8:0] bit_len;
    bit_len = {msg_len, 3'b000};
    if (idx == msg_len)      return 8'h80;
    else if (idx == 6'd62)   return {7'd0, bit_len[8]};
    else if (idx == 6'd63)   return bit_len[7:0];
    else                     return 8'h00;
  endfunction

  // msg_ready is forced low while rst is held so every output reads 0 in reset.
  assign msg_ready = !rst && ((state == S_IDLE) || (state == S_LOAD_MSG));
  assign busy      = (state != S_IDLE);
  assign msg_fire  = msg_valid && msg_ready;
  assign tmo_hit   = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST);

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (msg_fire) state_nxt = msg_last ? S_PAD : S_LOAD_MSG;
      S_LOAD_MSG:  if (msg_fire && msg_last) state_nxt = S_PAD;
      S_PAD:       if (load_cnt == LAST_LOAD) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_HASH;
      S_WAIT_HASH: begin
        if (core_hash_ready) state_nxt = S_RD_CAP;
        else if (tmo_hit)    state_nxt = S_IDLE;
      end
      S_RD_CAP:    state_nxt = S_RD_OUT;
      S_RD_OUT:    if (dig_ready) state_nxt = (rd_idx == LAST_DIG) ? S_IDLE : S_RD_GAP;
      S_RD_GAP:    state_nxt = S_RD_CAP;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // ---- output / datapath next values ----
  always_comb begin
    load_nxt      = 1'b0;
    start_nxt     = 1'b0;
    read_nxt      = 1'b0;
    bus_nxt       = core_input_bus;
    dig_data_nxt  = dig_data;
    dig_valid_nxt = dig_valid;
    dig_last_nxt  = dig_last;
    err_ovf_nxt   = err_overflow;
    err_tmo_nxt   = err_timeout;
    count_nxt     = count;
    load_cnt_nxt  = load_cnt;
    rd_idx_nxt    = rd_idx;
    tmo_cnt_nxt   = tmo_cnt;
    case (state)
      S_IDLE: begin
        if (msg_fire) begin
          err_ovf_nxt  = 1'b0;
          err_tmo_nxt  = 1'b0;
          load_nxt     = 1'b1;
          bus_nxt      = msg_data;
          count_nxt    = 6'd1;
          load_cnt_nxt = 6'd1;
        end
      end
      S_LOAD_MSG: begin
        if (msg_fire) begin
          if (count < MSG_MAX) begin
            load_nxt     = 1'b1;
            bus_nxt      = msg_data;
            count_nxt    = count + 6'd1;
            load_cnt_nxt = load_cnt + 6'd1;
          end else begin
            // Excess bytes are drained so the source is not stalled.
            err_ovf_nxt = 1'b1;
          end
        end
      end
      S_PAD: begin
        load_nxt     = 1'b1;
        bus_nxt      = pad_byte(load_cnt, count);
        load_cnt_nxt = load_cnt + 6'd1;
      end
      S_START: begin
        start_nxt   = 1'b1;
        tmo_cnt_nxt = '0;
      end
      S_WAIT_HASH: begin
        if (core_hash_ready) rd_idx_nxt = 5'd0;
        else if (tmo_hit)    err_tmo_nxt = 1'b1;
        else                 tmo_cnt_nxt = tmo_cnt + 1'b1;
      end
      S_RD_CAP: begin
        dig_data_nxt  = core_output_data;
        dig_valid_nxt = 1'b1;
        dig_last_nxt  = (rd_idx == LAST_DIG);
      end
      S_RD_OUT: begin
        if (dig_ready) begin
          dig_valid_nxt = 1'b0;
          dig_last_nxt  = 1'b0;
          if (rd_idx != LAST_DIG) begin
            read_nxt   = 1'b1;
            rd_idx_nxt = rd_idx + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---- registered outputs and counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_load      <= 1'b0;
      core_start     <= 1'b0;
      core_read      <= 1'b0;
      core_input_bus <= 8'h00;
      dig_data       <= 8'h00;
      dig_valid      <= 1'b0;
      dig_last       <= 1'b0;
      err_overflow   <= 1'b0;
      err_timeout    <= 1'b0;
      count          <= 6'd0;
      load_cnt       <= 6'd0;
      rd_idx         <= 5'd0;
      tmo_cnt        <= '0;
    end else begin
      core_load      <= load_nxt;
      core_start     <= start_nxt;
      core_read      <= read_nxt;
      core_input_bus <= bus_nxt;
      dig_data       <= dig_data_nxt;
      dig_valid      <= dig_valid_nxt;
      dig_last       <= dig_last_nxt;
      err_overflow   <= err_ovf_nxt;
      err_timeout    <= err_tmo_nxt;
      count          <= count_nxt;
      load_cnt       <= load_cnt_nxt;
      rd_idx         <= rd_idx_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
    end
  end

endmodule
